// File: rtl/irqgen_pkg.sv
// irqgen_pkg: shared mode constants, channel state enum and default widths for the IRQ generator.
package irqgen_pkg;
  localparam logic IRQGEN_ONESHOT    = 1'b0;
  localparam logic IRQGEN_CONTINUOUS = 1'b1;
  localparam int IRQGEN_DEF_LINES    = 16;
  localparam int IRQGEN_DEF_CHANNELS = 4;
  localparam int IRQGEN_DEF_RATE_W   = 16;
  localparam int IRQGEN_DEF_AMT_W    = 12;
  localparam int IRQGEN_DEF_LAT_W    = 16;
  typedef enum logic {CH_IDLE, CH_RUN} ch_state_e;
  function automatic int clog2_min1(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/irqgen_channel.sv
// irqgen_channel: one generator channel with throttle, handled count and saturating service latency.
module irqgen_channel
  import irqgen_pkg::*;
#(
  parameter int RATE_W = IRQGEN_DEF_RATE_W,
  parameter int AMT_W  = IRQGEN_DEF_AMT_W,
  parameter int LAT_W  = IRQGEN_DEF_LAT_W,
  parameter int LINE_W = 4
)(
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              cfg_load,
  input  logic [RATE_W-1:0] cfg_rate,
  input  logic [AMT_W-1:0]  cfg_amt,
  input  logic [LINE_W-1:0] cfg_line,
  input  logic              cfg_mode,
  input  logic              start,
  input  logic              stop,
  input  logic              ack,
  output logic              busy,
  output logic              pending,
  output logic              done,
  output logic [LINE_W-1:0] line,
  output logic [AMT_W-1:0]  count,
  output logic [LAT_W-1:0]  lat_last,
  output logic [LAT_W-1:0]  lat_max
);
  ch_state_e st, st_nxt;
  logic [RATE_W-1:0] rate, thr;
  logic [AMT_W-1:0] amt, cnt_inc;
  logic [LAT_W-1:0] lat_cnt, lat_new;
  logic mode, fire, finish, done_nxt;

  assign busy    = st == CH_RUN;
  assign cnt_inc = count + AMT_W'(1);
  assign lat_new = &lat_cnt ? lat_cnt : lat_cnt + LAT_W'(1);
  assign fire    = !pending && thr >= rate && (mode == IRQGEN_CONTINUOUS || count < amt);
  // amt = 0 in one-shot mode completes while idle-pending, before any IRQ is raised
  assign finish  = busy && mode == IRQGEN_ONESHOT && (ack ? cnt_inc == amt : !pending && count >= amt);

  always_ff @(posedge ACLK or posedge ARESET)
    if (ARESET) st <= CH_IDLE;
    else st <= st_nxt;

  always_comb begin
    st_nxt   = stop ? CH_IDLE : busy ? (finish ? CH_IDLE : CH_RUN) : start ? CH_RUN : CH_IDLE;
    done_nxt = busy && !stop && finish;
  end

  always_ff @(posedge ACLK or posedge ARESET)
    if (ARESET) begin
      done     <= 1'b0;
      pending  <= 1'b0;
      thr      <= '0;
      count    <= '0;
      lat_cnt  <= '0;
      lat_last <= '0;
      lat_max  <= '0;
      rate     <= '0;
      amt      <= '0;
      line     <= '0;
      mode     <= IRQGEN_ONESHOT;
    end else begin
      done <= done_nxt;
      if (cfg_load && !busy) begin
        rate <= cfg_rate;
        amt  <= cfg_amt;
        line <= cfg_line;
        mode <= cfg_mode;
      end
      if (!busy) begin
        pending <= 1'b0;
        thr     <= '0;
        if (start && !stop) begin
          count    <= '0;
          lat_cnt  <= '0;
          lat_last <= '0;
          lat_max  <= '0;
        end
      end else if (stop) begin
        pending <= 1'b0;
        thr     <= '0;
      end else if (pending) begin
        if (ack) begin
          pending  <= 1'b0;
          count    <= cnt_inc;
          lat_last <= lat_new;
          lat_max  <= lat_new > lat_max ? lat_new : lat_max;
        end else lat_cnt <= lat_new;
      end else if (fire) begin
        pending <= 1'b1;
        thr     <= '0;
        lat_cnt <= '0;
      end else thr <= thr + RATE_W'(1);
    end
endmodule

// File: rtl/irqgen_multichannel_controller.sv
// irqgen_multichannel_controller: multi-channel IRQ generator with cfg decode, ack fan-out,
// per-line IRQ OR-reduction and a registered latency/count readout.
module irqgen_multichannel_controller
  import irqgen_pkg::*;
#(
  parameter int C_AMOUNT_OF_IRQLINES = IRQGEN_DEF_LINES,
  parameter int C_NUM_CHANNELS       = IRQGEN_DEF_CHANNELS,
  parameter int C_WIDTH_OF_IRQRATE   = IRQGEN_DEF_RATE_W,
  parameter int C_WIDTH_OF_IRQAMT    = IRQGEN_DEF_AMT_W,
  parameter int C_WIDTH_OF_LATENCY   = IRQGEN_DEF_LAT_W,
  localparam int LW = clog2_min1(C_AMOUNT_OF_IRQLINES),
  localparam int CW = clog2_min1(C_NUM_CHANNELS)
)(
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic                            cfg_we,
  input  logic [CW-1:0]                   cfg_ch,
  input  logic [C_WIDTH_OF_IRQRATE-1:0]   cfg_rate,
  input  logic [C_WIDTH_OF_IRQAMT-1:0]    cfg_amt,
  input  logic [LW-1:0]                   cfg_line,
  input  logic                            cfg_mode,
  input  logic [C_NUM_CHANNELS-1:0]       start,
  input  logic [C_NUM_CHANNELS-1:0]       stop,
  input  logic                            handled_valid,
  input  logic [LW-1:0]                   handled_line,
  input  logic [CW-1:0]                   lat_sel,
  output logic [C_AMOUNT_OF_IRQLINES-1:0] irq_out,
  output logic [C_NUM_CHANNELS-1:0]       busy,
  output logic [C_NUM_CHANNELS-1:0]       done,
  output logic                            cfg_err,
  output logic                            spurious_ack,
  output logic [C_WIDTH_OF_LATENCY-1:0]   lat_last_o,
  output logic [C_WIDTH_OF_LATENCY-1:0]   lat_max_o,
  output logic [C_WIDTH_OF_IRQAMT-1:0]    count_o
);
  logic [C_NUM_CHANNELS-1:0] cfg_sel, pend, hit;
  logic [LW-1:0] ch_line [C_NUM_CHANNELS];
  logic [C_WIDTH_OF_IRQAMT-1:0] ch_cnt [C_NUM_CHANNELS];
  logic [C_WIDTH_OF_LATENCY-1:0] ch_last [C_NUM_CHANNELS];
  logic [C_WIDTH_OF_LATENCY-1:0] ch_max [C_NUM_CHANNELS];
  logic sel_ok;

  for (genvar i = 0; i < C_NUM_CHANNELS; i++) begin : g_ch
    assign cfg_sel[i] = cfg_we && cfg_ch == CW'(i);
    assign hit[i]     = handled_valid && pend[i] && ch_line[i] == handled_line;
    irqgen_channel #(
      .RATE_W(C_WIDTH_OF_IRQRATE),
      .AMT_W (C_WIDTH_OF_IRQAMT),
      .LAT_W (C_WIDTH_OF_LATENCY),
      .LINE_W(LW)
    ) u_ch (
      .ACLK    (ACLK),
      .ARESET  (ARESET),
      .cfg_load(cfg_sel[i]),
      .cfg_rate(cfg_rate),
      .cfg_amt (cfg_amt),
      .cfg_line(cfg_line),
      .cfg_mode(cfg_mode),
      .start   (start[i]),
      .stop    (stop[i]),
      .ack     (hit[i]),
      .busy    (busy[i]),
      .pending (pend[i]),
      .done    (done[i]),
      .line    (ch_line[i]),
      .count   (ch_cnt[i]),
      .lat_last(ch_last[i]),
      .lat_max (ch_max[i])
    );
  end

  // pending is only ever set while running, so it alone drives the line
  always_comb begin
    irq_out = '0;
    for (int i = 0; i < C_NUM_CHANNELS; i++)
      if (pend[i]) irq_out[ch_line[i]] = 1'b1;
  end

  assign sel_ok = int'(lat_sel) < C_NUM_CHANNELS;

  always_ff @(posedge ACLK or posedge ARESET)
    if (ARESET) begin
      cfg_err      <= 1'b0;
      spurious_ack <= 1'b0;
      lat_last_o   <= '0;
      lat_max_o    <= '0;
      count_o      <= '0;
    end else begin
      cfg_err      <= |(cfg_sel & busy);
      spurious_ack <= handled_valid && !(|hit);
      lat_last_o   <= sel_ok ? ch_last[lat_sel] : '0;
      lat_max_o    <= sel_ok ? ch_max[lat_sel] : '0;
      count_o      <= sel_ok ? ch_cnt[lat_sel] : '0;
    end
endmodule

// File: tb/tb_irqgen_multichannel_controller.sv
// tb_irqgen_multichannel_controller: directed and random stimulus against an event-level model
// that predicts IRQ times by arithmetic on edge indices.
module tb_irqgen_multichannel_controller;
  localparam int NL = 16, NC = 4, RW = 16, AW = 12, LATW = 4, LW = 4, CW = 2;
  localparam int LMAX = (1 << LATW) - 1;

  logic ACLK = 1'b0, ARESET = 1'b0;
  logic cfg_we = 1'b0, cfg_mode = 1'b0, handled_valid = 1'b0;
  logic [CW-1:0] cfg_ch = '0, lat_sel = '0;
  logic [RW-1:0] cfg_rate = '0;
  logic [AW-1:0] cfg_amt = '0;
  logic [LW-1:0] cfg_line = '0, handled_line = '0;
  logic [NC-1:0] start = '0, stop = '0;
  logic [NL-1:0] irq_out;
  logic [NC-1:0] busy, done;
  logic cfg_err, spurious_ack;
  logic [LATW-1:0] lat_last_o, lat_max_o;
  logic [AW-1:0] count_o;

  always #5 ACLK = ~ACLK;

  irqgen_multichannel_controller #(
    .C_AMOUNT_OF_IRQLINES(NL), .C_NUM_CHANNELS(NC), .C_WIDTH_OF_IRQRATE(RW),
    .C_WIDTH_OF_IRQAMT(AW), .C_WIDTH_OF_LATENCY(LATW)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_rate(cfg_rate),
    .cfg_amt(cfg_amt), .cfg_line(cfg_line), .cfg_mode(cfg_mode), .start(start), .stop(stop),
    .handled_valid(handled_valid), .handled_line(handled_line), .lat_sel(lat_sel),
    .irq_out(irq_out), .busy(busy), .done(done), .cfg_err(cfg_err), .spurious_ack(spurious_ack),
    .lat_last_o(lat_last_o), .lat_max_o(lat_max_o), .count_o(count_o)
  );

  int n_checks = 0, n_fail = 0, cyc = 0;
  bit m_run [NC], m_pend [NC];
  int m_next [NC], m_set [NC], m_cnt [NC], m_last [NC], m_max [NC];
  int m_rate [NC], m_amt [NC], m_line [NC], m_mode [NC];
  logic [NC-1:0] e_done = '0;
  logic e_cfg_err = 1'b0, e_spur = 1'b0;
  int e_last = 0, e_max = 0, e_cnt = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      m_run[c] = 0; m_pend[c] = 0; m_next[c] = 0; m_set[c] = 0; m_cnt[c] = 0;
      m_last[c] = 0; m_max[c] = 0; m_rate[c] = 0; m_amt[c] = 0; m_line[c] = 0; m_mode[c] = 0;
    end
    e_done = '0; e_cfg_err = 0; e_spur = 0; e_last = 0; e_max = 0; e_cnt = 0;
  endtask

  // Applies one clock edge (index cyc) to the model using the inputs sampled there.
  task automatic model_edge();
    bit hit [NC];
    bit any = 0;
    int s = int'(lat_sel), lat;
    e_last = m_last[s]; e_max = m_max[s]; e_cnt = m_cnt[s];
    e_cfg_err = 0; e_done = '0;
    for (int c = 0; c < NC; c++) begin
      hit[c] = handled_valid && m_run[c] && m_pend[c] && m_line[c] == int'(handled_line);
      any |= hit[c];
    end
    e_spur = handled_valid && !any;
    for (int c = 0; c < NC; c++) begin
      if (cfg_we && int'(cfg_ch) == c) begin
        if (m_run[c]) e_cfg_err = 1;
        else begin
          m_rate[c] = int'(cfg_rate); m_amt[c] = int'(cfg_amt);
          m_line[c] = int'(cfg_line); m_mode[c] = int'(cfg_mode);
        end
      end
      if (m_run[c]) begin
        if (stop[c]) begin
          m_run[c] = 0; m_pend[c] = 0;
        end else if (hit[c]) begin
          lat = cyc - m_set[c];
          if (lat > LMAX) lat = LMAX;
          m_last[c] = lat;
          if (lat > m_max[c]) m_max[c] = lat;
          m_cnt[c] = (m_cnt[c] + 1) % (1 << AW);
          m_pend[c] = 0;
          if (m_mode[c] == 0 && m_cnt[c] == m_amt[c]) begin
            m_run[c] = 0; e_done[c] = 1;
          end else m_next[c] = cyc + m_rate[c] + 1;
        end else if (!m_pend[c]) begin
          if (m_mode[c] == 0 && m_cnt[c] >= m_amt[c]) begin
            m_run[c] = 0; e_done[c] = 1;
          end else if (cyc == m_next[c]) begin
            m_pend[c] = 1; m_set[c] = cyc;
          end
        end
      end else if (start[c] && !stop[c]) begin
        m_run[c] = 1; m_cnt[c] = 0; m_last[c] = 0; m_max[c] = 0;
        m_next[c] = cyc + m_rate[c] + 1;
      end
    end
  endtask

  task automatic check_all();
    logic [NL-1:0] ei = '0;
    logic [NC-1:0] eb = '0;
    for (int c = 0; c < NC; c++) begin
      if (m_pend[c]) ei[m_line[c]] = 1'b1;
      eb[c] = m_run[c];
    end
    chk("irq_out", 32'(irq_out), 32'(ei));
    chk("busy", 32'(busy), 32'(eb));
    chk("done", 32'(done), 32'(e_done));
    chk("cfg_err", 32'(cfg_err), 32'(e_cfg_err));
    chk("spurious_ack", 32'(spurious_ack), 32'(e_spur));
    chk("lat_last_o", 32'(lat_last_o), e_last);
    chk("lat_max_o", 32'(lat_max_o), e_max);
    chk("count_o", 32'(count_o), e_cnt);
  endtask

  task automatic step();
    @(posedge ACLK);
    model_edge();
    cyc++;
    #1 check_all();
    cfg_we = 0; start = '0; stop = '0; handled_valid = 0;
  endtask

  task automatic cfg(int ch, int rate, int amt, int line, int mode);
    cfg_we = 1; cfg_ch = CW'(ch); cfg_rate = RW'(rate); cfg_amt = AW'(amt);
    cfg_line = LW'(line); cfg_mode = mode[0];
  endtask

  task automatic ack(int line);
    handled_valid = 1; handled_line = LW'(line);
  endtask

  initial begin
    model_reset();
    #2 ARESET = 1;
    #1;
    chk("rst_irq", 32'(irq_out), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_lat", 32'(lat_last_o), 0);
    chk("rst_count", 32'(count_o), 0);
    @(negedge ACLK) ARESET = 0;

    // ch0 one-shot: rate 3, amt 2, line 5, ack four cycles after each IRQ
    cfg(0, 3, 2, 5, 0); step();
    start = 4'b0001; step();
    chk("t1_busy", 32'(busy[0]), 1);
    repeat (3) step();
    chk("t1_irq_early", 32'(irq_out[5]), 0);
    step();
    chk("t1_irq_e4", 32'(irq_out[5]), 1);
    repeat (3) step();
    ack(5); step();
    chk("t1_irq_acked", 32'(irq_out[5]), 0);
    repeat (3) step();
    chk("t1_irq_gap", 32'(irq_out[5]), 0);
    step();
    chk("t1_irq_e12", 32'(irq_out[5]), 1);
    repeat (3) step();
    ack(5); step();
    chk("t1_done", 32'(done[0]), 1);
    chk("t1_busy_fall", 32'(busy[0]), 0);
    step();
    chk("t1_lat_last", 32'(lat_last_o), 4);
    chk("t1_count", 32'(count_o), 2);

    // ch1 continuous, rate 0, amt 0, immediate acks, then stop
    cfg(1, 0, 0, 9, 1); step();
    start = 4'b0010; step();
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t2_irq_high", 32'(irq_out[9]), 1);
      ack(9); step();
      chk("t2_irq_low", 32'(irq_out[9]), 0);
    end
    lat_sel = 2'd1; step();
    chk("t2_count", 32'(count_o), 5);
    chk("t2_irq_again", 32'(irq_out[9]), 1);
    stop = 4'b0010; step();
    chk("t2_stop_irq", 32'(irq_out[9]), 0);
    chk("t2_stop_busy", 32'(busy[1]), 0);
    chk("t2_no_done", 32'(done[1]), 0);

    // ch0 and ch2 share line 7; one ack services both; then an ack on idle line 3
    cfg(0, 1, 3, 7, 0); step();
    cfg(2, 1, 3, 7, 1); step();
    start = 4'b0101; step();
    step(); step();
    chk("t3_shared_irq", 32'(irq_out[7]), 1);
    ack(7); step();
    chk("t3_shared_clr", 32'(irq_out[7]), 0);
    lat_sel = 2'd0; step();
    chk("t3_count0", 32'(count_o), 1);
    lat_sel = 2'd2; step();
    chk("t3_count2", 32'(count_o), 1);
    ack(3); step();
    chk("t3_spurious", 32'(spurious_ack), 1);

    // write to a running channel is rejected; start while running is ignored
    cfg(0, 9, 9, 2, 1); step();
    chk("t4_cfg_err", 32'(cfg_err), 1);
    start = 4'b0001; step();
    chk("t4_line_kept", 32'(irq_out[7]), 1);
    chk("t4_line_new", 32'(irq_out[2]), 0);
    ack(7); step();
    stop = 4'b0101; step();
    chk("t4_all_idle", 32'(busy), 0);

    // ch3 ack withheld long enough to saturate the 4-bit latency
    cfg(3, 0, 1, 12, 0); step();
    start = 4'b1000; step();
    step();
    repeat (20) step();
    ack(12); step();
    chk("t5_done", 32'(done[3]), 1);
    lat_sel = 2'd3; step();
    chk("t5_lat_last", 32'(lat_last_o), LMAX);
    chk("t5_lat_max", 32'(lat_max_o), LMAX);

    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 7) == 0)
        cfg($urandom_range(0, 3), $urandom_range(0, 5), $urandom_range(0, 4),
            $urandom_range(0, 3), $urandom_range(0, 1));
      start = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      stop = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(0, 15)) : '0;
      if ($urandom_range(0, 2) == 0) ack($urandom_range(0, 3));
      lat_sel = 2'($urandom_range(0, 3));
      step();
    end

    // asynchronous reset in the middle of a continuous run
    stop = '1; step();
    cfg(0, 0, 0, 1, 1); step();
    start = 4'b0001; step();
    step();
    ack(1); step();
    lat_sel = 2'd0; step();
    chk("t6_pre_busy", 32'(busy[0]), 1);
    chk("t6_pre_irq", 32'(irq_out[1]), 1);
    chk("t6_pre_lat", 32'(lat_last_o), 1);
    #2 ARESET = 1;
    #1;
    chk("t6_rst_irq", 32'(irq_out), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_last", 32'(lat_last_o), 0);
    chk("t6_rst_max", 32'(lat_max_o), 0);
    chk("t6_rst_count", 32'(count_o), 0);
    model_reset();
    @(negedge ACLK) ARESET = 0;
    repeat (5) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
